// File: rtl/data_memory_dbg_if.sv
// Pipeline data-memory port and debug dump stream between the MEM stage, the
// debug unit and data_memory_dbg.
interface data_memory_dbg_if #(
  parameter int NB_ADDR = 12
);
  logic [NB_ADDR-1:0] i_addr;
  logic [31:0]        i_data;
  logic [1:0]         i_write_enable;
  logic [1:0]         i_read_enable;
  logic               i_signed;
  logic [31:0]        o_data;
  logic               o_misaligned;
  logic               o_busy;
  logic               i_dbg_start;
  logic               i_dbg_ready;
  logic               o_dbg_valid;
  logic [31:0]        o_dbg_data;
  logic [NB_ADDR-3:0] o_dbg_addr;
  logic               o_dbg_done;

  modport master (
    output i_addr, i_data, i_write_enable, i_read_enable, i_signed,
    output i_dbg_start, i_dbg_ready,
    input  o_data, o_misaligned, o_busy,
    input  o_dbg_valid, o_dbg_data, o_dbg_addr, o_dbg_done
  );

  modport slave (
    input  i_addr, i_data, i_write_enable, i_read_enable, i_signed,
    input  i_dbg_start, i_dbg_ready,
    output o_data, o_misaligned, o_busy,
    output o_dbg_valid, o_dbg_data, o_dbg_addr, o_dbg_done
  );
endinterface

// File: rtl/data_memory_dbg.sv
// Byte-addressed MEM-stage data memory with lane steering, sub-word extension,
// alignment checking and a valid/ready debug dump engine.
module data_memory_dbg #(
  parameter  int RAM_WIDTH = 32,
  parameter  int NB_ADDR   = 12,
  localparam int DEPTH     = 2 ** (NB_ADDR - 2)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  data_memory_dbg_if.slave  bus
);
  localparam int AW    = NB_ADDR - 2;
  localparam int LANES = RAM_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} state_t;

  state_t                 state_q, state_d;
  logic [AW-1:0]          ptr_q, ptr_d;
  logic [AW-1:0]          dbg_addr_q, dbg_addr_d;
  logic [RAM_WIDTH-1:0]   dbg_data_q, dbg_data_d;
  logic [RAM_WIDTH-1:0]   mem [DEPTH];

  logic [AW-1:0]          widx;
  logic [1:0]             lane;
  logic                   busy;
  logic                   misaligned;
  logic [LANES-1:0]       lane_en;
  logic [RAM_WIDTH-1:0]   wdata;

  function automatic logic bad_align(input logic [1:0] en, input logic [1:0] ln);
    case (en)
      2'b10:   return ln[0];
      2'b11:   return ln != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  // Right-align the addressed lane(s) and extend; word loads ignore sgn.
  function automatic logic [31:0] extend_load(input logic [31:0] word,
                                              input logic [1:0]  en,
                                              input logic [1:0]  ln,
                                              input logic        sgn);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(word >> {ln, 3'b000});
    h = ln[1] ? word[31:16] : word[15:0];
    case (en)
      2'b01:   return {{24{sgn & b[7]}}, b};
      2'b10:   return {{16{sgn & h[15]}}, h};
      2'b11:   return word;
      default: return 32'h0;
    endcase
  endfunction

  assign widx       = bus.i_addr[NB_ADDR-1:2];
  assign lane       = bus.i_addr[1:0];
  assign busy       = state_q != IDLE;
  assign misaligned = bad_align(bus.i_write_enable, lane) | bad_align(bus.i_read_enable, lane);

  always_comb begin
    lane_en = '0;
    wdata   = bus.i_data;
    if (!busy && !misaligned) begin
      case (bus.i_write_enable)
        2'b01: begin
          lane_en = LANES'(1) << lane;
          wdata   = {4{bus.i_data[7:0]}};
        end
        2'b10: begin
          lane_en = lane[1] ? 4'b1100 : 4'b0011;
          wdata   = {2{bus.i_data[15:0]}};
        end
        2'b11:   lane_en = '1;
        default: lane_en = '0;
      endcase
    end
  end

  // Storage is never reset; only the dump engine state is.
  always_ff @(posedge i_clk) begin
    for (int l = 0; l < LANES; l++) begin
      if (lane_en[l]) mem[widx][8*l +: 8] <= wdata[8*l +: 8];
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    dbg_addr_d = dbg_addr_q;
    dbg_data_d = dbg_data_q;
    case (state_q)
      IDLE: begin
        if (bus.i_dbg_start) begin
          state_d = FETCH;
          ptr_d   = '0;
        end
      end
      FETCH: begin
        dbg_data_d = mem[ptr_q];
        dbg_addr_d = ptr_q;
        state_d    = SEND;
      end
      SEND: begin
        if (bus.i_dbg_ready) begin
          if (ptr_q == AW'(DEPTH - 1)) begin
            state_d = DONE;
          end else begin
            ptr_d   = ptr_q + AW'(1);
            state_d = FETCH;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      dbg_addr_q <= '0;
      dbg_data_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      dbg_addr_q <= dbg_addr_d;
      dbg_data_q <= dbg_data_d;
    end
  end

  assign bus.o_data       = (busy || misaligned) ? 32'h0
                          : extend_load(mem[widx], bus.i_read_enable, lane, bus.i_signed);
  assign bus.o_misaligned = misaligned;
  assign bus.o_busy       = busy;
  assign bus.o_dbg_valid  = state_q == SEND;
  assign bus.o_dbg_done   = state_q == DONE;
  assign bus.o_dbg_data   = dbg_data_q;
  assign bus.o_dbg_addr   = dbg_addr_q;
endmodule
